pix_pair_packer: RTL and testbench
==================================

// Module: pix_pair_packer
// PURPOSE
//  Capture-side stage that feeds the pixel processor. Packs a stream of 18-bit RGB 6:6:6
//  pixels into 36-bit two-pixel words, each tagged with its 19-bit ZBT word address.
//  A small FIFO absorbs downstream stalls. Outputs drive two_pixel_vals / write_addr directly.
// PARAMETERS
//  BASE_ADDR    19'd0       ZBT word address of the first word in each frame
//  FRAME_WORDS  19'd153600  words per frame (640x480/2); address wraps after this many
//  DEPTH_LOG2   3           FIFO depth = 2**DEPTH_LOG2 entries (each entry 55 bits: data+addr)
// PORTS
//  clk             in   1   pixel clock
//  reset           in   1   asynchronous, active-high reset
//  pix_valid       in   1   pix_data valid this cycle
//  pix_data        in   18  {R[5:0],G[5:0],B[5:0]}
//  sof             in   1   start of frame; qualified by pix_valid; marks first pixel of frame
//  word_ready      in   1   downstream accepts the word this cycle
//  word_valid      out  1   FIFO non-empty; head word presented
//  two_pixel_vals  out  36  head word {first_pixel, second_pixel}
//  write_addr      out  19  ZBT word address of the head word
//  overflow        out  1   sticky: a completed word was dropped because the FIFO was full
//  dropped_cnt     out  16  (PACK_STATS_EN only) count of dropped words
// BEHAVIOUR
//  - Reset (async, any time, including mid-pair or mid-drain): FIFO emptied, phase=0,
//    half register=0, next_addr=BASE_ADDR, overflow=0. Outputs word_valid=0,
//    two_pixel_vals=0, write_addr=0.
//  - Packing: phase=0 & pix_valid -> latch pix_data into half[17:0], phase<=1.
//    phase=1 & pix_valid -> complete word {half, pix_data}, phase<=0.
//    Cycles without pix_valid change nothing.
//  - sof & pix_valid: pending half word discarded (not counted as dropped). This pixel
//    becomes the first of a pair (phase<=1). next_addr<=BASE_ADDR, so the word it starts
//    gets BASE_ADDR.
//  - Address: each completed word takes next_addr. next_addr then increments, wrapping
//    BASE_ADDR+FRAME_WORDS-1 -> BASE_ADDR. It advances even when the word is dropped,
//    so frame geometry is preserved.
//  - FIFO: push on word completion; pop when word_valid & word_ready.
//    Push to full FIFO with simultaneous pop: accepted.
//    Push to full FIFO without pop: word dropped, overflow<=1.
//    Pop while empty: ignored.
//    Push and pop on an empty FIFO: pushed word appears next cycle (no bypass).
//  - Latency: word visible on outputs (word_valid=1) the cycle after the second pixel's
//    pix_valid cycle, if the FIFO was empty.
//  - Outputs come straight from registered FIFO head storage; 0 when empty. Order strictly FIFO.
//  - overflow is cleared only by reset.
//  - Pointer arithmetic: DEPTH_LOG2+1 bits; full = MSBs differ & LSBs equal.
// CONFIGURATION
//  PACK_STATS_EN defined: dropped_cnt port exists. 16-bit counter, +1 per dropped word,
//    saturates at 16'hFFFF, reset to 0.
//  PACK_STATS_EN undefined: no dropped_cnt port and no counter logic. All other
//    behaviour is identical.
// TESTING (bench uses FRAME_WORDS=4, DEPTH_LOG2=3, BASE_ADDR=0 unless noted)
//  1 reset; sof+pix 18'h00001, then pix 18'h00002, ready=1
//    -> next cycle word_valid=1, two_pixel_vals=36'h000040002, write_addr=0; popped same cycle.
//  2 sof then 16 consecutive pixels, ready=1
//    -> 8 words with write_addr 0,1,2,3,0,1,2,3; data pairs in input order.
//  3 ready=0, push 9 words -> overflow=1, dropped_cnt=1 (if PACK_STATS_EN).
//    Then ready=1 -> 8 words drain, addr 0,1,2,3,0,1,2,3. Next new word has addr 1
//    (the 9th word took addr 0 and was dropped).
//  4 pix A (no sof), then sof+pix B, pix C -> A discarded; one word {B,C} at addr 0.
//  5 reset asserted with 3 words queued and phase=1
//    -> word_valid/two_pixel_vals/write_addr/overflow=0 immediately.
//    After release, first pair gets addr BASE_ADDR (run with BASE_ADDR=19'h100 -> 19'h100).
//  6 FIFO full, push and pop in the same cycle -> no drop; overflow stays 0.
//    Pop order is preserved.

Source files
------------

// File: rtl/pix_pair_packer.sv
// Packs 18-bit RGB 6:6:6 pixels into 36-bit two-pixel words tagged with ZBT word addresses, queued in a small FIFO.
// Define PACK_STATS_EN to add the saturating dropped_cnt output.
module pix_pair_packer #(
    parameter logic [18:0] BASE_ADDR   = 19'd0,
    parameter logic [18:0] FRAME_WORDS = 19'd153600,
    parameter int unsigned DEPTH_LOG2  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [17:0] pix_data,
    input  logic        sof,
    input  logic        word_ready,
    output logic        word_valid,
    output logic [35:0] two_pixel_vals,
    output logic [18:0] write_addr,
`ifdef PACK_STATS_EN
    output logic        overflow,
    output logic [15:0] dropped_cnt
`else
    output logic        overflow
`endif
);

    localparam int unsigned PTR_W     = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [18:0] LAST_ADDR = BASE_ADDR + FRAME_WORDS - 19'd1;

    typedef struct packed {
        logic [35:0] data;
        logic [18:0] addr;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             phase_q, phase_d;
    logic [17:0]      half_q, half_d;
    logic [18:0]      next_addr_q, next_addr_d;
    logic             overflow_q;
    logic             word_done, empty, full, pop, push, drop;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        phase_d     = phase_q;
        half_d      = half_q;
        next_addr_d = next_addr_q;
        word_done   = 1'b0;
        if (pix_valid) begin
            if (sof) begin
                half_d      = pix_data;
                phase_d     = 1'b1;
                next_addr_d = BASE_ADDR;
            end else if (phase_q) begin
                word_done   = 1'b1;
                phase_d     = 1'b0;
                next_addr_d = (next_addr_q == LAST_ADDR) ? BASE_ADDR : next_addr_q + 19'd1;
            end else begin
                half_d  = pix_data;
                phase_d = 1'b1;
            end
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign pop   = !empty && word_ready;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push  = word_done && (!full || pop);
    assign drop  = word_done && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= 1'b0;
            half_q      <= '0;
            next_addr_q <= BASE_ADDR;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            half_q      <= half_d;
            next_addr_q <= next_addr_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (drop) overflow_q <= 1'b1;
        end
    end

    // NOTE: storage is not reset; the outputs are masked while empty, so stale entries never show.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= '{data: {half_q, pix_data}, addr: next_addr_q};
    end

    assign word_valid     = !empty;
    assign two_pixel_vals = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]].data;
    assign write_addr     = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]].addr;
    assign overflow       = overflow_q;

`ifdef PACK_STATS_EN
    logic [15:0] dropped_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropped_cnt_q <= '0;
        end else if (drop && dropped_cnt_q != 16'hFFFF) begin
            dropped_cnt_q <= dropped_cnt_q + 16'd1;
        end
    end

    assign dropped_cnt = dropped_cnt_q;
`endif

endmodule

// File: tb/tb_pix_pair_packer.sv
// Self-checking bench for pix_pair_packer: directed scenarios plus random traffic against a queue-based model.
// Two instances share the stimulus: BASE_ADDR 0 and BASE_ADDR 19'h100.
module tb_pix_pair_packer;

    localparam logic [18:0] FW     = 19'd4;
    localparam logic [18:0] BASE_B = 19'h100;
    localparam int          DEPTH  = 8;

    logic        clk = 1'b0, reset = 1'b0, pix_valid = 1'b0, sof = 1'b0, word_ready = 1'b0;
    logic [17:0] pix_data = '0;
    logic        word_valid, overflow, word_valid_b, overflow_b;
    logic [35:0] two_pixel_vals, two_pixel_vals_b;
    logic [18:0] write_addr, write_addr_b;
`ifdef PACK_STATS_EN
    logic [15:0] dropped_cnt, dropped_cnt_b;
`endif

    always #5 clk = ~clk;

    pix_pair_packer #(.BASE_ADDR(19'd0), .FRAME_WORDS(FW), .DEPTH_LOG2(3)) u_dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data), .sof(sof),
        .word_ready(word_ready), .word_valid(word_valid), .two_pixel_vals(two_pixel_vals),
        .write_addr(write_addr),
`ifdef PACK_STATS_EN
        .dropped_cnt(dropped_cnt),
`endif
        .overflow(overflow)
    );

    pix_pair_packer #(.BASE_ADDR(BASE_B), .FRAME_WORDS(FW), .DEPTH_LOG2(3)) u_dut_b (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data), .sof(sof),
        .word_ready(word_ready), .word_valid(word_valid_b), .two_pixel_vals(two_pixel_vals_b),
        .write_addr(write_addr_b),
`ifdef PACK_STATS_EN
        .dropped_cnt(dropped_cnt_b),
`endif
        .overflow(overflow_b)
    );

    typedef struct { logic [35:0] data; logic [18:0] off; } word_t;
    typedef struct { logic pv; logic [17:0] pd; logic sof; logic rdy; } stim_t;

    word_t       mq[$];
    logic [17:0] m_half;
    bit          m_have;
    logic [18:0] m_off;
    bit          m_ovf;
    int          m_drop;
    stim_t       st[$];
    logic [54:0] got[$];
    int          n_cmp = 0, n_fail = 0;

    function automatic logic [56:0] model_out(input logic [18:0] base);
        if (mq.size() == 0) return {1'b0, 36'd0, 19'd0, m_ovf};
        return {1'b1, mq[0].data, base + mq[0].off, m_ovf};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_half = '0; m_have = 0; m_off = '0; m_ovf = 0; m_drop = 0;
    endtask

    task automatic apply(input stim_t s);
        pix_valid = s.pv; pix_data = s.pd; sof = s.sof; word_ready = s.rdy;
    endtask

    // Model update for the upcoming edge, then advance to 1 time unit after it.
    task automatic tick();
        bit pop_now;
        pop_now = (mq.size() > 0) && word_ready;
        if (pop_now) void'(mq.pop_front());
        if (pix_valid) begin
            if (sof) begin
                m_half = pix_data; m_have = 1; m_off = '0;
            end else if (m_have) begin
                if (mq.size() < DEPTH) mq.push_back('{{m_half, pix_data}, m_off});
                else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
                m_off  = (m_off == FW - 19'd1) ? 19'd0 : m_off + 19'd1;
                m_have = 0;
            end else begin
                m_half = pix_data; m_have = 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        pix_valid = 0; sof = 0; word_ready = 0; pix_data = '0;
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        st.delete(); got.delete();
    endtask

    task automatic test_reset();
        reset = 1;
        #1;
        n_cmp++;
        if ({word_valid, two_pixel_vals, write_addr, overflow} !== 57'd0 ||
            {word_valid_b, two_pixel_vals_b, write_addr_b, overflow_b} !== 57'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h / %h expected 0", {word_valid, two_pixel_vals, write_addr, overflow},
                     {word_valid_b, two_pixel_vals_b, write_addr_b, overflow_b});
        end
`ifdef PACK_STATS_EN
        n_cmp++;
        if (dropped_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_dropped_cnt: got %0d expected 0", dropped_cnt);
        end
`endif
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        st.push_back('{1'b1, 18'h00001, 1'b1, 1'b1});
        st.push_back('{1'b1, 18'h00002, 1'b0, 1'b1});
        repeat (2) st.push_back('{1'b0, 18'h0, 1'b0, 1'b1});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            n_cmp++;
            if ({word_valid, two_pixel_vals, write_addr, overflow} !== model_out(19'd0)) begin
                n_fail++;
                $display("FAIL single c%0d: got %h expected %h", i, {word_valid, two_pixel_vals, write_addr, overflow}, model_out(19'd0));
            end
            if (i == 2) begin
                n_cmp++;
                if ({word_valid, two_pixel_vals, write_addr} !== {1'b1, 36'h000040002, 19'd0}) begin
                    n_fail++;
                    $display("FAIL single_latency: got %h expected %h", {word_valid, two_pixel_vals, write_addr}, {1'b1, 36'h000040002, 19'd0});
                end
            end
            tick();
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 16; i++) st.push_back('{1'b1, 18'($urandom), i == 0, 1'b1});
        repeat (3) st.push_back('{1'b0, 18'h0, 1'b0, 1'b1});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            n_cmp++;
            if ({word_valid, two_pixel_vals, write_addr, overflow} !== model_out(19'd0)) begin
                n_fail++;
                $display("FAIL stream c%0d: got %h expected %h", i, {word_valid, two_pixel_vals, write_addr, overflow}, model_out(19'd0));
            end
            if (word_valid && st[i].rdy) got.push_back({two_pixel_vals, write_addr});
            tick();
        end
        n_cmp++;
        if (got.size() != 8) begin
            n_fail++; $display("FAIL stream_count: got %0d words expected 8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (got[k][18:0] !== 19'(k % 4)) begin
                    n_fail++; $display("FAIL stream_addr[%0d]: got %0d expected %0d", k, got[k][18:0], k % 4);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 18; i++) st.push_back('{1'b1, 18'($urandom), i == 0, 1'b0});
        repeat (10) st.push_back('{1'b0, 18'h0, 1'b0, 1'b1});
        repeat (2) st.push_back('{1'b1, 18'($urandom), 1'b0, 1'b1});
        repeat (3) st.push_back('{1'b0, 18'h0, 1'b0, 1'b1});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            n_cmp++;
            if ({word_valid, two_pixel_vals, write_addr, overflow} !== model_out(19'd0)) begin
                n_fail++;
                $display("FAIL overflow c%0d: got %h expected %h", i, {word_valid, two_pixel_vals, write_addr, overflow}, model_out(19'd0));
            end
            if (i == 18) begin
                n_cmp++;
                if (overflow !== 1'b1) begin
                    n_fail++; $display("FAIL overflow_flag: got %b expected 1", overflow);
                end
`ifdef PACK_STATS_EN
                n_cmp++;
                if (dropped_cnt !== 16'd1) begin
                    n_fail++; $display("FAIL overflow_dropped_cnt: got %0d expected 1", dropped_cnt);
                end
`endif
            end
            if (word_valid && st[i].rdy) got.push_back({two_pixel_vals, write_addr});
            tick();
        end
        n_cmp++;
        if (got.size() != 9) begin
            n_fail++; $display("FAIL overflow_count: got %0d words expected 9", got.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                n_cmp++;
                if (got[k][18:0] !== ((k == 8) ? 19'd1 : 19'(k % 4))) begin
                    n_fail++; $display("FAIL overflow_addr[%0d]: got %0d expected %0d", k, got[k][18:0], (k == 8) ? 1 : k % 4);
                end
            end
        end
    endtask

    task automatic test_sof_discard();
        logic [17:0] a, b, c;
        do_reset();
        a = 18'($urandom); b = 18'($urandom); c = 18'($urandom);
        st.push_back('{1'b1, a, 1'b0, 1'b1});
        st.push_back('{1'b1, b, 1'b1, 1'b1});
        st.push_back('{1'b1, c, 1'b0, 1'b1});
        repeat (3) st.push_back('{1'b0, 18'h0, 1'b0, 1'b1});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            n_cmp++;
            if ({word_valid, two_pixel_vals, write_addr, overflow} !== model_out(19'd0)) begin
                n_fail++;
                $display("FAIL sof_discard c%0d: got %h expected %h", i, {word_valid, two_pixel_vals, write_addr, overflow}, model_out(19'd0));
            end
            if (word_valid && st[i].rdy) got.push_back({two_pixel_vals, write_addr});
            tick();
        end
        n_cmp++;
        if (got.size() != 1 || got[0] !== {b, c, 19'd0}) begin
            n_fail++; $display("FAIL sof_discard_word: got %0d words, first %h expected one word %h", got.size(), (got.size() > 0) ? got[0] : 55'd0, {b, c, 19'd0});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) st.push_back('{1'b1, 18'($urandom), i == 0, 1'b0});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            n_cmp++;
            if ({word_valid_b, two_pixel_vals_b, write_addr_b, overflow_b} !== model_out(BASE_B)) begin
                n_fail++;
                $display("FAIL reset_mid_fill c%0d: got %h expected %h", i, {word_valid_b, two_pixel_vals_b, write_addr_b, overflow_b}, model_out(BASE_B));
            end
            tick();
        end
        pix_valid = 0; sof = 0; word_ready = 0;
        reset = 1;
        #1;
        n_cmp++;
        if ({word_valid, two_pixel_vals, write_addr, overflow} !== 57'd0 ||
            {word_valid_b, two_pixel_vals_b, write_addr_b, overflow_b} !== 57'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h / %h expected 0", {word_valid, two_pixel_vals, write_addr, overflow},
                     {word_valid_b, two_pixel_vals_b, write_addr_b, overflow_b});
        end
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        st.delete();
        repeat (2) st.push_back('{1'b1, 18'($urandom), 1'b0, 1'b1});
        repeat (2) st.push_back('{1'b0, 18'h0, 1'b0, 1'b1});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            n_cmp++;
            if ({word_valid, two_pixel_vals, write_addr, overflow} !== model_out(19'd0) ||
                {word_valid_b, two_pixel_vals_b, write_addr_b, overflow_b} !== model_out(BASE_B)) begin
                n_fail++;
                $display("FAIL reset_mid_after c%0d: got %h / %h expected %h / %h", i, {word_valid, two_pixel_vals, write_addr, overflow},
                         {word_valid_b, two_pixel_vals_b, write_addr_b, overflow_b}, model_out(19'd0), model_out(BASE_B));
            end
            if (i == 2) begin
                n_cmp++;
                if ({word_valid_b, write_addr_b} !== {1'b1, 19'h100}) begin
                    n_fail++; $display("FAIL reset_mid_base_addr: got valid %b addr %h expected 1 / 100", word_valid_b, write_addr_b);
                end
            end
            tick();
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 17; i++) st.push_back('{1'b1, 18'($urandom), i == 0, 1'b0});
        st.push_back('{1'b1, 18'($urandom), 1'b0, 1'b1});
        repeat (10) st.push_back('{1'b0, 18'h0, 1'b0, 1'b1});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            n_cmp++;
            if ({word_valid, two_pixel_vals, write_addr, overflow} !== model_out(19'd0)) begin
                n_fail++;
                $display("FAIL full_push_pop c%0d: got %h expected %h", i, {word_valid, two_pixel_vals, write_addr, overflow}, model_out(19'd0));
            end
            if (word_valid && st[i].rdy) got.push_back({two_pixel_vals, write_addr});
            tick();
        end
        n_cmp++;
        if (overflow !== 1'b0 || got.size() != 9) begin
            n_fail++; $display("FAIL full_push_pop_nodrop: got overflow %b words %0d expected 0 / 9", overflow, got.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++)
            st.push_back('{($urandom_range(99) < 70), 18'($urandom), ($urandom_range(99) < 5), ($urandom_range(99) < 55)});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            n_cmp++;
            if ({word_valid, two_pixel_vals, write_addr, overflow} !== model_out(19'd0) ||
                {word_valid_b, two_pixel_vals_b, write_addr_b, overflow_b} !== model_out(BASE_B)) begin
                n_fail++;
                $display("FAIL random c%0d: got %h / %h expected %h / %h", i, {word_valid, two_pixel_vals, write_addr, overflow},
                         {word_valid_b, two_pixel_vals_b, write_addr_b, overflow_b}, model_out(19'd0), model_out(BASE_B));
            end
`ifdef PACK_STATS_EN
            n_cmp++;
            if (dropped_cnt !== 16'(m_drop)) begin
                n_fail++; $display("FAIL random_dropped_cnt c%0d: got %0d expected %0d", i, dropped_cnt, m_drop);
            end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_overflow();
        test_sof_discard();
        test_reset_mid();
        test_full_push_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
